// File: rtl/mem_wait_slave_pkg.sv
// rtl/mem_wait_slave_pkg.sv - shared state encoding and default sizes for mem_wait_slave
package mem_wait_slave_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_WAIT_W = 3;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

endpackage

// File: rtl/mem_wait_slave_ram.sv
// rtl/mem_wait_slave_ram.sv - word array, synchronous write, asynchronous read
module mem_wait_slave_ram
  import mem_wait_slave_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  // Contents are deliberately not reset; the write port is the only way in.
  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_wait_slave.sv
// rtl/mem_wait_slave.sv - wait-state read target: FSM, wait counter, data register, counters
module mem_wait_slave
  import mem_wait_slave_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int WAIT_W = DEF_WAIT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WAIT_W-1:0] waits,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ws,
  output logic              rdy,
  output logic [DATA_W-1:0] data,
  output logic [7:0]        rd_count,
  output logic              abort
);

  state_t            state;
  state_t            w_next;
  logic              w_start;
  logic              w_abort;
  logic              w_done;
  logic [ADDR_W-1:0] r_addr_q;
  logic [WAIT_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_data;
  logic [7:0]        r_rd_count;
  logic              r_abort;
  logic [DATA_W-1:0] w_rdata;

  mem_wait_slave_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clock   (clock),
    .i_we    (we),
    .i_waddr (waddr),
    .i_wdata (wdata),
    .i_raddr (r_addr_q),
    .o_rdata (w_rdata)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= w_next;
  end

  // Next state plus one-cycle start/abort/completion events.
  always_comb begin
    w_next  = state;
    w_start = 1'b0;
    w_abort = 1'b0;
    w_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (rd) begin
          w_start = 1'b1;
          w_next  = (waits != '0) ? S_WAIT : S_READY;
        end
      end
      S_WAIT: begin
        if (!rd) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else if (r_cnt == WAIT_W'(1)) begin
          w_next = S_READY;
        end
      end
      S_READY: begin
        if (!rd) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Address and wait count are captured only at transaction start, so later
  // changes on addr/waits cannot disturb a read in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr_q <= '0;
      r_cnt    <= '0;
    end else if (w_start) begin
      r_addr_q <= addr;
      r_cnt    <= waits;
    end else if (state == S_WAIT) begin
      r_cnt <= r_cnt - WAIT_W'(1);
    end
  end

  // Re-sampling every READY cycle lets a write to the addressed word show up one edge later.
  always_ff @(posedge clock) begin
    if (reset)                  r_data <= '0;
    else if (state == S_READY)  r_data <= w_rdata;
  end

  // Completed-read counter and sticky abort flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_count <= 8'd0;
      r_abort    <= 1'b0;
    end else begin
      if (w_done)  r_rd_count <= r_rd_count + 8'd1;
      if (w_abort) r_abort    <= 1'b1;
    end
  end

  assign ws       = (state == S_WAIT);
  assign rdy      = (state == S_READY);
  assign data     = r_data;
  assign rd_count = r_rd_count;
  assign abort    = r_abort;

endmodule

// File: tb/tb_mem_wait_slave.sv
// tb/tb_mem_wait_slave.sv - directed self-checking bench for mem_wait_slave
module tb_mem_wait_slave;
  import mem_wait_slave_pkg::*;

  logic       clock;
  logic       reset;
  logic       rd;
  logic [3:0] addr;
  logic [2:0] waits;
  logic       we;
  logic [3:0] waddr;
  logic [7:0] wdata;
  logic       ws;
  logic       rdy;
  logic [7:0] data;
  logic [7:0] rd_count;
  logic       abort;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_wait_slave #(.DATA_W(8), .ADDR_W(4), .WAIT_W(3)) dut (
    .clock    (clock),
    .reset    (reset),
    .rd       (rd),
    .addr     (addr),
    .waits    (waits),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .ws       (ws),
    .rdy      (rdy),
    .data     (data),
    .rd_count (rd_count),
    .abort    (abort)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [3:0] a, input logic [7:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  typedef enum int {C_READ, C_DELAY, C_DONE} ctl_t;

  initial begin
    ctl_t ctl;
    bit   reached;
    reset = 1'b1; rd = 1'b0; addr = '0; waits = '0; we = 1'b0; waddr = '0; wdata = '0;
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    check("rst_ws", 32'(ws), 32'd0);
    check("rst_rdy", 32'(rdy), 32'd0);
    check("rst_data", 32'(data), 32'h00);
    check("rst_rd_count", 32'(rd_count), 32'd0);
    check("rst_abort", 32'(abort), 32'd0);
    check("rst_state", 32'(dut.state), 32'(S_IDLE));

    // Zero-wait read of mem[3]: rd high for cycles 0 and 1.
    preload(4'd3, 8'hA5);
    rd = 1'b1; addr = 4'd3; waits = 3'd0;
    check("n0_c0_ws", 32'(ws), 32'd0);
    tick();
    check("n0_c1_ws", 32'(ws), 32'd0);
    check("n0_c1_rdy", 32'(rdy), 32'd1);
    tick();
    rd = 1'b0;
    check("n0_c2_data", 32'(data), 32'hA5);
    check("n0_c2_rdy", 32'(rdy), 32'd1);
    tick();
    check("n0_c3_rdy", 32'(rdy), 32'd0);
    check("n0_c3_data", 32'(data), 32'hA5);
    check("n0_c3_rd_count", 32'(rd_count), 32'd1);

    // Three wait states with a READ/DELAY controller; addr/waits scrambled after cycle 0.
    preload(4'd7, 8'h3C);
    ctl = C_READ;
    reached = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc == 0) begin addr = 4'd7; waits = 3'd3; end
      else          begin addr = 4'd0; waits = 3'd0; end
      rd = (ctl != C_DONE);
      if (ctl == C_DONE) begin
        check("n3_done_cycle", 32'(cyc), 32'd6);
        check("n3_done_data", 32'(data), 32'h3C);
        reached = 1'b1;
        tick();
        break;
      end
      check($sformatf("n3_c%0d_ws", cyc), 32'(ws), 32'((cyc >= 1) && (cyc <= 3)));
      case (ctl)
        C_READ:  ctl = C_DELAY;
        C_DELAY: ctl = ws ? C_READ : C_DONE;
        default: ctl = C_DONE;
      endcase
      tick();
    end
    if (!reached) check("n3_timeout", 32'd0, 32'd1);
    check("n3_rdy_after", 32'(rdy), 32'd0);
    check("n3_rd_count", 32'(rd_count), 32'd2);

    // Abort: waits=4, rd dropped in cycle 2.
    rd = 1'b1; addr = 4'd3; waits = 3'd4;
    tick();
    check("ab_c1_ws", 32'(ws), 32'd1);
    tick();
    rd = 1'b0;
    tick();
    check("ab_abort", 32'(abort), 32'd1);
    check("ab_state", 32'(dut.state), 32'(S_IDLE));
    check("ab_data", 32'(data), 32'h3C);
    check("ab_rd_count", 32'(rd_count), 32'd2);
    check("ab_ws", 32'(ws), 32'd0);

    // Write to the word being presented during READY.
    preload(4'd5, 8'h55);
    rd = 1'b1; addr = 4'd5; waits = 3'd0;
    tick();
    check("wr_c1_rdy", 32'(rdy), 32'd1);
    tick();
    check("wr_c2_data", 32'(data), 32'h55);
    we = 1'b1; waddr = 4'd5; wdata = 8'h11;
    tick();
    we = 1'b1; waddr = 4'd9; wdata = 8'hEE;
    check("wr_c3_data_old", 32'(data), 32'h55);
    tick();
    we = 1'b0;
    check("wr_c4_data_new", 32'(data), 32'h11);
    tick();
    check("wr_c5_data_indep", 32'(data), 32'h11);
    rd = 1'b0;
    tick();
    check("wr_rd_count", 32'(rd_count), 32'd3);
    check("wr_abort_sticky", 32'(abort), 32'd1);

    // Reset in the middle of S_WAIT, then a clean read.
    rd = 1'b1; addr = 4'd7; waits = 3'd5;
    tick();
    check("rw_c1_ws", 32'(ws), 32'd1);
    reset = 1'b1;
    tick();
    check("rw_ws", 32'(ws), 32'd0);
    check("rw_rdy", 32'(rdy), 32'd0);
    check("rw_data", 32'(data), 32'h00);
    check("rw_rd_count", 32'(rd_count), 32'd0);
    check("rw_abort", 32'(abort), 32'd0);
    check("rw_state", 32'(dut.state), 32'(S_IDLE));
    reset = 1'b0; rd = 1'b0;
    tick();
    rd = 1'b1; addr = 4'd7; waits = 3'd1;
    tick();
    check("pr_c1_ws", 32'(ws), 32'd1);
    tick();
    check("pr_c2_rdy", 32'(rdy), 32'd1);
    check("pr_c2_ws", 32'(ws), 32'd0);
    rd = 1'b0;
    tick();
    check("pr_data", 32'(data), 32'h3C);
    check("pr_rd_count", 32'(rd_count), 32'd1);
    check("pr_abort", 32'(abort), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
